// File: rtl/cpuif_arbiter_pkg.sv
// Shared types and helpers for the CPU-interface arbiter.
// Optional response timeout is enabled by defining CPUIF_ARB_TIMEOUT_EN.
package cpuif_arbiter_pkg;

  localparam int CPUIF_AW = 32;
  localparam int CPUIF_DW = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic                is_wr;
    logic [CPUIF_AW-1:0] addr;
    logic [CPUIF_DW-1:0] wr_data;
    logic [CPUIF_DW-1:0] wr_biten;
  } req_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // s is always below 2*n here, so one subtraction is a full modulo.
  function automatic int wrap_idx(input int s, input int n);
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/cpuif_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter
  import cpuif_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_j;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'(wrap_idx(int'(i_ptr) + k, N));
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/cpuif_arbiter.sv
// Round-robin sharing of one regblock CPU interface between N_REQ requesters.
// Define CPUIF_ARB_TIMEOUT_EN to add the TIMEOUT_CYCLES response timeout.
module cpuif_arbiter
  import cpuif_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef CPUIF_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic [N_REQ-1:0]            m_req,
  input  logic [N_REQ-1:0]            m_is_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] m_wr_data,
  input  logic [N_REQ*DATA_WIDTH-1:0] m_wr_biten,
  output logic [N_REQ-1:0]            m_ack,
  output logic                        m_err,
  output logic [DATA_WIDTH-1:0]       m_rd_data,
  output logic                        cpuif_req,
  output logic                        cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0]       cpuif_addr,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_biten,
  input  logic                        cpuif_req_stall_wr,
  input  logic                        cpuif_req_stall_rd,
  input  logic                        cpuif_rd_ack,
  input  logic                        cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]       cpuif_rd_data,
  input  logic                        cpuif_wr_ack,
  input  logic                        cpuif_wr_err
);

  localparam int IW = idx_width(N_REQ);

  state_e                r_state;
  req_t                  r_req;
  logic [N_REQ-1:0]      r_gnt;
  logic [IW-1:0]         r_ptr;
  logic                  r_cpuif_req;
  logic [N_REQ-1:0]      r_ack;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  req_t             w_pick;
  logic             w_stall, w_ack, w_err, w_done, w_to, w_timeout, w_block;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .i_req (m_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_comb begin
    w_pick.is_wr    = m_is_wr[w_idx];
    w_pick.addr     = CPUIF_AW'(m_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH]);
    w_pick.wr_data  = CPUIF_DW'(m_wr_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH]);
    w_pick.wr_biten = CPUIF_DW'(m_wr_biten[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH]);
  end

  assign w_stall = r_req.is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign w_ack   = r_req.is_wr ? cpuif_wr_ack : cpuif_rd_ack;
  assign w_err   = r_req.is_wr ? cpuif_wr_err : cpuif_rd_err;
  // An ack alongside a stalled request does not belong to this transaction.
  assign w_done  = ((r_state == ISSUE) && !w_stall && w_ack) || ((r_state == WAIT) && w_ack);
  assign w_to    = w_timeout && ((r_state == ISSUE) || (r_state == WAIT)) && !w_done;

`ifdef CPUIF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop, r_drop_wr;
  logic             w_drop_hit;

  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_drop_hit = r_drop_wr ? cpuif_wr_ack : cpuif_rd_ack;
  assign w_block    = r_drop;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt     <= '0;
      r_drop    <= 1'b0;
      r_drop_wr <= 1'b0;
    end else begin
      if ((r_state == ISSUE) || (r_state == WAIT)) r_cnt <= r_cnt + 1'b1;
      else                                         r_cnt <= '0;
      if (w_to) begin
        r_drop    <= 1'b1;
        r_drop_wr <= r_req.is_wr;
      end else if (r_drop && w_drop_hit) begin
        r_drop <= 1'b0;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_block   = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_gnt       <= '0;
      r_ptr       <= '0;
      r_cpuif_req <= 1'b0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (|m_req && !w_block) begin
            r_req       <= w_pick;
            r_gnt       <= w_gnt;
            r_ptr       <= IW'(wrap_idx(int'(w_idx) + 1, N_REQ));
            r_cpuif_req <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (w_done) begin
            r_cpuif_req <= 1'b0;
            r_ack       <= r_gnt;
            r_err       <= w_err;
            r_rd_data   <= r_req.is_wr ? '0 : cpuif_rd_data;
            r_state     <= RESP;
          end else if (w_to) begin
            r_cpuif_req <= 1'b0;
            r_ack       <= r_gnt;
            r_err       <= 1'b1;
            r_rd_data   <= '0;
            r_state     <= RESP;
          end else if ((r_state == ISSUE) && !w_stall) begin
            r_cpuif_req <= 1'b0;
            r_state     <= WAIT;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_ack           = r_ack;
  assign m_err           = r_err;
  assign m_rd_data       = r_rd_data;
  assign cpuif_req       = r_cpuif_req;
  assign cpuif_req_is_wr = r_req.is_wr;
  assign cpuif_addr      = ADDR_WIDTH'(r_req.addr);
  assign cpuif_wr_data   = DATA_WIDTH'(r_req.wr_data);
  assign cpuif_wr_biten  = DATA_WIDTH'(r_req.wr_biten);

endmodule

// File: tb/tb_cpuif_arbiter.sv
// Directed self-checking bench for cpuif_arbiter with two requesters.
module tb_cpuif_arbiter;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  m_req = '0, m_is_wr = '0;
  logic [63:0] m_addr = '0, m_wr_data = '0, m_wr_biten = '0;
  logic [1:0]  m_ack;
  logic        m_err;
  logic [31:0] m_rd_data;
  logic        cpuif_req, cpuif_req_is_wr;
  logic [31:0] cpuif_addr, cpuif_wr_data, cpuif_wr_biten;
  logic        cpuif_req_stall_wr = 0, cpuif_req_stall_rd = 0;
  logic        cpuif_rd_ack = 0, cpuif_rd_err = 0, cpuif_wr_ack = 0, cpuif_wr_err = 0;
  logic [31:0] cpuif_rd_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpuif_arbiter #(
    .N_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)
`ifdef CPUIF_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .m_req(m_req), .m_is_wr(m_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten),
    .m_ack(m_ack), .m_err(m_err), .m_rd_data(m_rd_data),
    .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr),
    .cpuif_addr(cpuif_addr), .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_biten(cpuif_wr_biten),
    .cpuif_req_stall_wr(cpuif_req_stall_wr), .cpuif_req_stall_rd(cpuif_req_stall_rd),
    .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
    .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    tick();
    tests++; if (m_ack !== 2'b00) begin fails++; $display("FAIL reset_m_ack got %b want 00", m_ack); end
    tests++; if (m_err !== 1'b0) begin fails++; $display("FAIL reset_m_err got %b want 0", m_err); end
    tests++; if (m_rd_data !== 32'h0) begin fails++; $display("FAIL reset_rd_data got %h want 0", m_rd_data); end
    tests++; if (cpuif_req !== 1'b0) begin fails++; $display("FAIL reset_cpuif_req got %b want 0", cpuif_req); end
    tests++; if ({cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten} !== 97'h0) begin
      fails++; $display("FAIL reset_payload got %b/%h/%h/%h want zeros", cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten);
    end
    arst_n = 1'b1;
    tick();
  endtask

  // Both requesters hold reads; the responder acks in the issue cycle.
  task automatic test_round_robin();
    logic [1:0]  exp_ack [4];
    logic [31:0] exp_dat;
    int n = 0;
    exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
    m_is_wr = 2'b00;
    m_addr  = {32'h0000_0020, 32'h0000_0010};
    m_req   = 2'b11;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      cpuif_rd_ack = 1'b0;
      if (m_ack != 2'b00) begin
        exp_dat = exp_ack[n][0] ? 32'h1000_0010 : 32'h1000_0020;
        tests++; if (m_ack !== exp_ack[n]) begin fails++; $display("FAIL rr_order[%0d] got %b want %b", n, m_ack, exp_ack[n]); end
        tests++; if (m_rd_data !== exp_dat) begin fails++; $display("FAIL rr_rd_data[%0d] got %h want %h", n, m_rd_data, exp_dat); end
        n++;
      end
      if (cpuif_req) begin
        cpuif_rd_ack  = 1'b1;
        cpuif_rd_data = 32'h1000_0000 | cpuif_addr;
      end
    end
    m_req = 2'b00;
    cpuif_rd_ack = 1'b0;
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_ack_count got %0d want 4", n); end
    tick();
  endtask

  task automatic test_write();
    m_req = 2'b01; m_is_wr = 2'b01;
    m_addr[31:0] = 32'h4; m_wr_data[31:0] = 32'hA5A5_0001; m_wr_biten[31:0] = 32'hFFFF_FFFF;
    tick();
    tests++; if (cpuif_req !== 1'b1) begin fails++; $display("FAIL wr_req_high got %b want 1", cpuif_req); end
    tests++; if ({cpuif_req_is_wr, cpuif_addr} !== {1'b1, 32'h4}) begin
      fails++; $display("FAIL wr_addr got %b/%h want 1/00000004", cpuif_req_is_wr, cpuif_addr);
    end
    tests++; if ({cpuif_wr_data, cpuif_wr_biten} !== {32'hA5A5_0001, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL wr_payload got %h/%h want a5a50001/ffffffff", cpuif_wr_data, cpuif_wr_biten);
    end
    tick();
    tests++; if (cpuif_req !== 1'b0) begin fails++; $display("FAIL wr_req_one_cycle got %b want 0", cpuif_req); end
    cpuif_wr_ack = 1'b1;
    tick();
    cpuif_wr_ack = 1'b0;
    tests++; if ({m_ack, m_err} !== 3'b010) begin fails++; $display("FAIL wr_m_ack got %b/%b want 01/0", m_ack, m_err); end
    m_req = 2'b00;
    tick();
    tests++; if ({m_ack, cpuif_req} !== 3'b000) begin fails++; $display("FAIL wr_after got %b/%b want 00/0", m_ack, cpuif_req); end
  endtask

  task automatic test_stall();
    int hi = 0, n_ack = 0, bad = 0;
    bit sent = 0;
    m_req = 2'b01; m_is_wr = 2'b00; m_addr[31:0] = 32'h8;
    cpuif_req_stall_rd = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      cpuif_rd_ack = 1'b0;
      if (m_ack != 2'b00) begin
        n_ack++;
        tests++; if ({m_ack, m_rd_data} !== {2'b01, 32'h55}) begin
          fails++; $display("FAIL stall_resp got %b/%h want 01/00000055", m_ack, m_rd_data);
        end
        m_req = 2'b00;
      end
      if (cpuif_req) begin
        hi++;
        if (cpuif_addr !== 32'h8 || cpuif_req_is_wr !== 1'b0) bad++;
        cpuif_req_stall_rd = (hi < 4);
      end else if (hi > 0 && !sent) begin
        cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h55; sent = 1;
      end
    end
    cpuif_req_stall_rd = 1'b0;
    tests++; if (hi !== 4) begin fails++; $display("FAIL stall_req_cycles got %0d want 4", hi); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stall_payload_unstable got %0d want 0", bad); end
    tests++; if (n_ack !== 1) begin fails++; $display("FAIL stall_ack_count got %0d want 1", n_ack); end
  endtask

  task automatic test_same_cycle_ack();
    m_req = 2'b10; m_is_wr = 2'b00; m_addr[63:32] = 32'h20;
    tick();
    tests++; if ({cpuif_req, cpuif_addr} !== {1'b1, 32'h20}) begin
      fails++; $display("FAIL sc_issue got %b/%h want 1/00000020", cpuif_req, cpuif_addr);
    end
    cpuif_rd_ack = 1'b1; cpuif_rd_err = 1'b1; cpuif_rd_data = 32'hDEAD_BEEF;
    tick();
    cpuif_rd_ack = 1'b0; cpuif_rd_err = 1'b0;
    tests++; if ({m_ack, m_err, m_rd_data} !== {2'b10, 1'b1, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL sc_resp got %b/%b/%h want 10/1/deadbeef", m_ack, m_err, m_rd_data);
    end
    tests++; if (cpuif_req !== 1'b0) begin fails++; $display("FAIL sc_req_drop got %b want 0", cpuif_req); end
    m_req = 2'b00;
    tick();
    tests++; if (m_ack !== 2'b00) begin fails++; $display("FAIL sc_single_pulse got %b want 00", m_ack); end
  endtask

  task automatic test_reset_in_wait();
    m_req = 2'b01; m_is_wr = 2'b01; m_addr[31:0] = 32'hC;
    tick();
    tick();
    arst_n = 1'b0;
    m_req  = 2'b00;
    #1;
    tests++; if ({m_ack, m_err, m_rd_data, cpuif_req, cpuif_req_is_wr, cpuif_addr} !== 69'h0) begin
      fails++; $display("FAIL rst_async got %b/%b/%h/%b/%b/%h want zeros", m_ack, m_err, m_rd_data, cpuif_req, cpuif_req_is_wr, cpuif_addr);
    end
    tick();
    arst_n = 1'b1;
    tick();
    cpuif_wr_ack = 1'b1;
    tick();
    cpuif_wr_ack = 1'b0;
    tick();
    tests++; if ({m_ack, cpuif_req} !== 3'b000) begin fails++; $display("FAIL rst_stray_ack got %b/%b want 00/0", m_ack, cpuif_req); end
    m_req = 2'b11; m_is_wr = 2'b00;
    m_addr = {32'h0000_0020, 32'h0000_0010};
    tick();
    tests++; if ({cpuif_req, cpuif_addr} !== {1'b1, 32'h10}) begin
      fails++; $display("FAIL rst_ptr_zero got %b/%h want 1/00000010", cpuif_req, cpuif_addr);
    end
    cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h1234;
    tick();
    cpuif_rd_ack = 1'b0;
    m_req = 2'b00;
    tests++; if ({m_ack, m_rd_data} !== {2'b01, 32'h1234}) begin
      fails++; $display("FAIL rst_next_ack got %b/%h want 01/00001234", m_ack, m_rd_data);
    end
    tick();
  endtask

`ifdef CPUIF_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c = 0;
    m_req = 2'b01; m_is_wr = 2'b00; m_addr[31:0] = 32'h30;
    while (c < 20 && m_ack == 2'b00) begin
      tick();
      c++;
    end
    m_req = 2'b00;
    tests++; if (c !== 9) begin fails++; $display("FAIL to_latency got %0d want 9", c); end
    tests++; if ({m_ack, m_err, m_rd_data, cpuif_req} !== {2'b01, 1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL to_resp got %b/%b/%h/%b want 01/1/0/0", m_ack, m_err, m_rd_data, cpuif_req);
    end
    tick();
    m_req = 2'b10; m_addr[63:32] = 32'h40;
    tick();
    tick();
    tests++; if (cpuif_req !== 1'b0) begin fails++; $display("FAIL to_blocked got %b want 0", cpuif_req); end
    cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h77;
    tick();
    cpuif_rd_ack = 1'b0;
    tests++; if (m_ack !== 2'b00) begin fails++; $display("FAIL to_late_ack got %b want 00", m_ack); end
    tick();
    tests++; if ({cpuif_req, cpuif_addr} !== {1'b1, 32'h40}) begin
      fails++; $display("FAIL to_next_issue got %b/%h want 1/00000040", cpuif_req, cpuif_addr);
    end
    cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'h99;
    tick();
    cpuif_rd_ack = 1'b0;
    m_req = 2'b00;
    tests++; if ({m_ack, m_err, m_rd_data} !== {2'b10, 1'b0, 32'h99}) begin
      fails++; $display("FAIL to_next_resp got %b/%b/%h want 10/0/00000099", m_ack, m_err, m_rd_data);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_stall();
    test_same_cycle_ack();
    test_reset_in_wait();
`ifdef CPUIF_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
